echo_ranger: RTL and testbench

ECHO_RANGER -- requirements
Module: echo_ranger

---
 rtl/ranger_pkg.sv | 27 ++
 rtl/dist_ring.sv | 43 ++++
 rtl/echo_ranger.sv | 181 ++++++++++++++++++
 tb/tb_echo_ranger.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ranger_pkg.sv
// Shared timing constants, distance type and FSM state encoding for the echo ranger.
package ranger_pkg;

  localparam int unsigned CLK_HZ         = 40_000_000;
  localparam int unsigned TRIG_CYCLES    = CLK_HZ / 1_000_000 * 12;  // 12 us
  localparam int unsigned PERIOD_CYCLES  = CLK_HZ / 1_000 * 60;      // 60 ms
  localparam int unsigned CYCLES_PER_MM  = 232;
  localparam int unsigned TIMEOUT_CYCLES = CLK_HZ / 1_000 * 30;      // 30 ms
  localparam int unsigned DEPTH          = 8;

  typedef logic [11:0] dist_t;

  localparam dist_t DIST_MAX = '1;

  typedef enum logic [2:0] {
    StIdle,
    StTrig,
    StWaitRise,
    StMeasure,
    StStore
  } ranger_state_t;

  function automatic dist_t sat_inc(dist_t d);
    return (d == DIST_MAX) ? d : d + dist_t'(1);
  endfunction

endpackage

// File: rtl/dist_ring.sv
// Ring buffer of recent distances; the entry at the write pointer is presented for eviction
// before it is overwritten. filled_o sets once the pointer has wrapped.
module dist_ring
  import ranger_pkg::*;
#(
  parameter int unsigned Depth = DEPTH
) (
  input  logic  clk,
  input  logic  reset,
  input  logic  we_i,
  input  dist_t wdata_i,
  output dist_t rdata_o,
  output logic  filled_o
);

  localparam int unsigned PtrW = $clog2(Depth);

  dist_t           mem_q [Depth];
  logic [PtrW-1:0] wp_q;
  logic            filled_q;
  logic            wp_last;

  assign wp_last  = (wp_q == PtrW'(Depth - 1));
  assign rdata_o  = mem_q[wp_q];
  assign filled_o = filled_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(Depth); i++) begin
        mem_q[i] <= '0;
      end
      wp_q     <= '0;
      filled_q <= 1'b0;
    end else if (we_i) begin
      mem_q[wp_q] <= wdata_i;
      wp_q        <= wp_last ? '0 : wp_q + PtrW'(1);
      if (wp_last) begin
        filled_q <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/echo_ranger.sv
// Ultrasonic ranger: periodic trigger, echo pulse-width measurement in mm, 8-deep history.
// Define RANGER_TIMEOUT_EN to abandon a missing or stuck echo and store 12'hFFF.
module echo_ranger
  import ranger_pkg::*;
#(
`ifdef RANGER_TIMEOUT_EN
  parameter int unsigned TimeoutCycles = TIMEOUT_CYCLES,
`endif
  parameter int unsigned TrigCycles    = TRIG_CYCLES,
  parameter int unsigned PeriodCycles  = PERIOD_CYCLES,
  parameter int unsigned CyclesPerMm   = CYCLES_PER_MM
) (
  input  logic  clk,
  input  logic  reset,
  input  logic  echo,
  output logic  trig,
  output dist_t newest,
  output dist_t oldest,
  output logic  valid,
  output logic  filled
);

  localparam int unsigned PeriodW = $clog2(PeriodCycles);
  localparam int unsigned TrigW   = $clog2(TrigCycles + 1);
  localparam int unsigned PreW    = $clog2(CyclesPerMm + 1);

  ranger_state_t      state_q;
  logic               trig_q, valid_q;
  logic [TrigW-1:0]   trig_cnt_q;
  logic [PreW-1:0]    pre_cnt_q;
  dist_t              dist_q, newest_q, oldest_q;
  logic [PeriodW-1:0] period_cnt_q;

  logic echo_meta_q, echo_sync_q, echo_prev_q;
  logic echo_rise, echo_fall;
  logic period_done, start_trig, timeout_hit;
  logic [PreW-1:0] pre_base, pre_step;
  dist_t           dist_base, dist_step;
  logic            pre_wrap;
  dist_t           ring_rdata;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      echo_meta_q <= 1'b0;
      echo_sync_q <= 1'b0;
      echo_prev_q <= 1'b0;
    end else begin
      echo_meta_q <= echo;
      echo_sync_q <= echo_meta_q;
      echo_prev_q <= echo_sync_q;
    end
  end

  assign echo_rise = echo_sync_q & ~echo_prev_q;
  assign echo_fall = ~echo_sync_q & echo_prev_q;

  // Saturates one short of the period so a late return to IDLE fires at once, and the
  // reset preload makes the very first IDLE cycle fire.
  assign period_done = (period_cnt_q == PeriodW'(PeriodCycles - 1));
  assign start_trig  = (state_q == StIdle) && period_done;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      period_cnt_q <= PeriodW'(PeriodCycles - 1);
    end else if (start_trig) begin
      period_cnt_q <= '0;
    end else if (!period_done) begin
      period_cnt_q <= period_cnt_q + PeriodW'(1);
    end
  end

`ifdef RANGER_TIMEOUT_EN
  localparam int unsigned ToW = $clog2(TimeoutCycles + 1);

  logic [ToW-1:0] to_cnt_q;
  logic           listening;

  assign listening   = (state_q == StWaitRise) || (state_q == StMeasure);
  assign timeout_hit = listening && (to_cnt_q == ToW'(TimeoutCycles - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      to_cnt_q <= '0;
    end else if (!listening) begin
      to_cnt_q <= '0;
    end else if (!timeout_hit) begin
      to_cnt_q <= to_cnt_q + ToW'(1);
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  // The rise cycle itself is the first echo-high cycle, so counting starts from zero there.
  always_comb begin
    pre_base  = (state_q == StMeasure) ? pre_cnt_q : '0;
    dist_base = (state_q == StMeasure) ? dist_q : '0;
    pre_wrap  = (pre_base == PreW'(CyclesPerMm - 1));
    pre_step  = pre_wrap ? '0 : pre_base + PreW'(1);
    dist_step = pre_wrap ? sat_inc(dist_base) : dist_base;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      trig_q     <= 1'b0;
      valid_q    <= 1'b0;
      trig_cnt_q <= '0;
      pre_cnt_q  <= '0;
      dist_q     <= '0;
      newest_q   <= '0;
      oldest_q   <= '0;
    end else begin
      valid_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start_trig) begin
            state_q    <= StTrig;
            trig_q     <= 1'b1;
            trig_cnt_q <= '0;
          end
        end
        StTrig: begin
          if (trig_cnt_q == TrigW'(TrigCycles - 1)) begin
            state_q <= StWaitRise;
            trig_q  <= 1'b0;
          end else begin
            trig_cnt_q <= trig_cnt_q + TrigW'(1);
          end
        end
        StWaitRise: begin
          if (timeout_hit) begin
            dist_q  <= DIST_MAX;
            state_q <= StStore;
            valid_q <= 1'b1;
          end else if (echo_rise) begin
            pre_cnt_q <= pre_step;
            dist_q    <= dist_step;
            state_q   <= StMeasure;
          end
        end
        StMeasure: begin
          if (timeout_hit) begin
            dist_q  <= DIST_MAX;
            state_q <= StStore;
            valid_q <= 1'b1;
          end else if (echo_fall) begin
            state_q <= StStore;
            valid_q <= 1'b1;
          end else if (echo_sync_q) begin
            pre_cnt_q <= pre_step;
            dist_q    <= dist_step;
          end
        end
        StStore: begin
          newest_q <= dist_q;
          oldest_q <= ring_rdata;
          state_q  <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  dist_ring #(
    .Depth (DEPTH)
  ) u_ring (
    .clk      (clk),
    .reset    (reset),
    .we_i     (state_q == StStore),
    .wdata_i  (dist_q),
    .rdata_o  (ring_rdata),
    .filled_o (filled)
  );

  assign trig   = trig_q;
  assign valid  = valid_q;
  assign newest = newest_q;
  assign oldest = oldest_q;

endmodule

// File: tb/tb_echo_ranger.sv
// Directed plus randomized bench for echo_ranger with shortened timing parameters and a
// queue-based model of the distance history.
module tb_echo_ranger;
  import ranger_pkg::*;

  localparam int unsigned TrigC = 10;
  localparam int unsigned PerC  = 2500;
  localparam int unsigned Cpm   = 3;
`ifdef RANGER_TIMEOUT_EN
  localparam int unsigned ToC   = 1500;
`endif
  localparam time Tclk = 10;

  logic  clk = 1'b0;
  logic  reset, echo;
  logic  trig, valid, filled;
  dist_t newest, oldest;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  dist_t       model_q[$];
  dist_t       exp_newest, exp_oldest;
  int unsigned n_stores;
  time         rise_t = 0;
  time         prev_rise_t = 0;

  always #(Tclk / 2) clk = ~clk;

  always @(posedge trig) begin
    prev_rise_t = rise_t;
    rise_t      = $time;
  end

  echo_ranger #(
`ifdef RANGER_TIMEOUT_EN
    .TimeoutCycles (ToC),
`endif
    .TrigCycles    (TrigC),
    .PeriodCycles  (PerC),
    .CyclesPerMm   (Cpm)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .echo   (echo),
    .trig   (trig),
    .newest (newest),
    .oldest (oldest),
    .valid  (valid),
    .filled (filled)
  );

  initial begin
    #(Tclk * 150000);
    $display("FAIL watchdog: observed no finish, expected finish within budget");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    model_q = {};
    repeat (DEPTH) model_q.push_back('0);
    n_stores   = 0;
    exp_newest = '0;
    exp_oldest = '0;
  endfunction

  function automatic void model_store(dist_t d);
    exp_oldest = model_q.pop_front();
    model_q.push_back(d);
    exp_newest = d;
    n_stores++;
  endfunction

  function automatic dist_t expect_dist(int unsigned h);
    int unsigned mm;
    mm = h / Cpm;
    return (mm > 4095) ? dist_t'(4095) : dist_t'(mm);
  endfunction

  task automatic wait_trig_rise();
    int unsigned n;
    n = 0;
    while (trig !== 1'b1 && n < PerC + 20) begin
      @(negedge clk);
      n++;
    end
    check("trig_rise_seen", 32'(trig), 32'd1);
  endtask

  task automatic trig_pulse();
    int unsigned w;
    wait_trig_rise();
    w = 0;
    while (trig === 1'b1 && w < TrigC + 20) begin
      w++;
      @(negedge clk);
    end
    check("trig_width", w, TrigC);
    check("newest_hold", 32'(newest), 32'(exp_newest));
    check("oldest_hold", 32'(oldest), 32'(exp_oldest));
  endtask

  task automatic wait_store();
    int unsigned n;
    n = 0;
    while (valid !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("valid_pulse", 32'(valid), 32'd1);
    @(negedge clk);
    check("valid_one_cycle", 32'(valid), 32'd0);
    check("newest", 32'(newest), 32'(exp_newest));
    check("oldest", 32'(oldest), 32'(exp_oldest));
    check("filled", 32'(filled), 32'(n_stores >= DEPTH));
  endtask

  task automatic measure(input int unsigned dly, input int unsigned h, input bit chk_period);
    trig_pulse();
    if (chk_period) check("period", 32'((rise_t - prev_rise_t) / Tclk), PerC);
    repeat (dly) @(negedge clk);
    echo = 1'b1;
    repeat (h) @(negedge clk);
    echo = 1'b0;
    model_store(expect_dist(h));
    wait_store();
  endtask

  initial begin
    int unsigned n;
    reset = 1'b1;
    echo  = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check("rst_trig", 32'(trig), 32'd0);
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_filled", 32'(filled), 32'd0);
    check("rst_newest", 32'(newest), 32'd0);
    check("rst_oldest", 32'(oldest), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    check("first_trig", 32'(trig), 32'd1);

    // 100 mm echo into an empty history
    measure(5, 100 * Cpm, 1'b0);

    // Reset in the middle of a trigger pulse
    wait_trig_rise();
    repeat (3) @(negedge clk);
    reset = 1'b1;
    #1;
    check("trig_drop_on_reset", 32'(trig), 32'd0);
    check("newest_cleared", 32'(newest), 32'd0);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("trig_after_reset", 32'(trig), 32'd1);
    measure(3, 42 * Cpm, 1'b0);

    // Reset 100 cycles into a measurement
    trig_pulse();
    repeat (4) @(negedge clk);
    echo = 1'b1;
    repeat (100) @(negedge clk);
    reset = 1'b1;
    #1;
    check("meas_rst_trig", 32'(trig), 32'd0);
    check("meas_rst_valid", 32'(valid), 32'd0);
    check("meas_rst_newest", 32'(newest), 32'd0);
    check("meas_rst_oldest", 32'(oldest), 32'd0);
    model_reset();
    echo = 1'b0;
    repeat (2) begin
      @(negedge clk);
      check("meas_rst_no_valid", 32'(valid), 32'd0);
    end
    reset = 1'b0;
    @(negedge clk);
    check("meas_rst_first_trig", 32'(trig), 32'd1);

    // Nine stores of k mm: wraps the history and sets filled on the eighth
    for (int k = 1; k <= 9; k++) begin
      measure(2 + k, k * Cpm, k > 1);
    end

    // Random echo lengths, including ones that are not whole millimetres
    for (int i = 0; i < 6; i++) begin
      measure($urandom_range(1, 30), $urandom_range(1, 900), 1'b1);
    end

    // Echo already high before trig falls must be ignored; only the second pulse counts
    wait_trig_rise();
    repeat (2) @(negedge clk);
    echo = 1'b1;
    n = 0;
    while (trig === 1'b1 && n < TrigC + 20) begin
      @(negedge clk);
      n++;
    end
    check("period_e", 32'((rise_t - prev_rise_t) / Tclk), PerC);
    repeat (6) @(negedge clk);
    echo = 1'b0;
    repeat (8) @(negedge clk);
    echo = 1'b1;
    repeat (10 * Cpm) @(negedge clk);
    echo = 1'b0;
    model_store(dist_t'(10));
    wait_store();

`ifdef RANGER_TIMEOUT_EN
    // No echo at all: timeout stores 12'hFFF, next trig stays on the period grid
    trig_pulse();
    for (int m = 1; m <= int'(ToC) + 1; m++) begin
      @(negedge clk);
      if (m == int'(ToC)) check("timeout_not_early", 32'(newest == DIST_MAX), 32'd0);
    end
    model_store(DIST_MAX);
    check("timeout_newest", 32'(newest), 32'(exp_newest));
    check("timeout_oldest", 32'(oldest), 32'(exp_oldest));
    wait_trig_rise();
    check("timeout_period", 32'((rise_t - prev_rise_t) / Tclk), PerC);
`else
    // Very long echo saturates and overruns the period; next trig follows IDLE entry
    measure(4, 4100 * Cpm, 1'b1);
    @(negedge clk);
    check("overrun_trig", 32'(trig), 32'd1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
